// File: rtl/bounce_generator.sv
// Emulates a chattering mechanical contact; optional LFSR chatter via BOUNCE_GENERATOR_LFSR_EN.
// Latency: output follows clean_in changes after BOUNCE_TICKS chatter cycles.
// Backpressure: none; clean_in is sampled every cycle.
module bounce_generator #(
    parameter int         BOUNCE_TICKS = 10,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clean_in,
    output logic       bouncy_out,
    output logic       settling,
    output logic [7:0] settle_count
);

    localparam int             CW   = $clog2(BOUNCE_TICKS) + 1;
    localparam logic [CW-1:0] LAST = CW'(BOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        S_STABLE_0    = 2'd0,
        S_BOUNCE_TO_1 = 2'd1,
        S_STABLE_1    = 2'd2,
        S_BOUNCE_TO_0 = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_counter;
    logic [CW-1:0]   w_counter_nxt;
    logic [7:0]      r_settle_count;
    logic            w_settle_inc;
    logic            w_pattern_bit;

`ifdef BOUNCE_GENERATOR_LFSR_EN
    // A zero seed would lock the LFSR at zero forever.
    localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [7:0] r_lfsr;
    logic       w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        end
    end

    assign w_pattern_bit = r_lfsr[0];
`else
    logic w_target;
    logic w_unused_seed;

    assign w_unused_seed = ^LFSR_SEED;
    assign w_target      = (r_state == S_BOUNCE_TO_1);
    assign w_pattern_bit = w_target ^ r_counter[0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_STABLE_0;
            r_counter      <= '0;
            r_settle_count <= 8'h00;
        end else begin
            r_state   <= w_state_nxt;
            r_counter <= w_counter_nxt;
            if (w_settle_inc && (r_settle_count != 8'hFF)) begin
                r_settle_count <= r_settle_count + 8'h01;
            end
        end
    end

    // Reversal is tested before completion so a late flip never counts as a settle.
    always_comb begin
        w_state_nxt   = r_state;
        w_counter_nxt = r_counter;
        w_settle_inc  = 1'b0;
        bouncy_out    = 1'b0;
        settling      = 1'b0;
        case (r_state)
            S_STABLE_0: begin
                if (clean_in) begin
                    w_state_nxt   = S_BOUNCE_TO_1;
                    w_counter_nxt = '0;
                end
            end
            S_BOUNCE_TO_1: begin
                bouncy_out = w_pattern_bit;
                settling   = 1'b1;
                if (!clean_in) begin
                    w_state_nxt   = S_BOUNCE_TO_0;
                    w_counter_nxt = '0;
                end else if (r_counter == LAST) begin
                    w_state_nxt   = S_STABLE_1;
                    w_counter_nxt = '0;
                    w_settle_inc  = 1'b1;
                end else begin
                    w_counter_nxt = r_counter + 1'b1;
                end
            end
            S_STABLE_1: begin
                bouncy_out = 1'b1;
                if (!clean_in) begin
                    w_state_nxt   = S_BOUNCE_TO_0;
                    w_counter_nxt = '0;
                end
            end
            S_BOUNCE_TO_0: begin
                bouncy_out = w_pattern_bit;
                settling   = 1'b1;
                if (clean_in) begin
                    w_state_nxt   = S_BOUNCE_TO_1;
                    w_counter_nxt = '0;
                end else if (r_counter == LAST) begin
                    w_state_nxt   = S_STABLE_0;
                    w_counter_nxt = '0;
                    w_settle_inc  = 1'b1;
                end else begin
                    w_counter_nxt = r_counter + 1'b1;
                end
            end
            default: begin
                w_state_nxt   = S_STABLE_0;
                w_counter_nxt = '0;
            end
        endcase
    end

    assign settle_count = r_settle_count;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: edges, reversal, async reset, saturation, zero seed.
module tb_bounce_generator;

    logic       clk;
    logic       rst;
    logic       clean_in;
    logic       bouncy_out;
    logic       settling;
    logic [7:0] settle_count;
    logic       z_bouncy_out;
    logic       z_settling;
    logic [7:0] z_settle_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] m_lfsr;
    logic [7:0] m_lfsr_z;

    bounce_generator #(.BOUNCE_TICKS(10), .LFSR_SEED(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .clean_in     (clean_in),
        .bouncy_out   (bouncy_out),
        .settling     (settling),
        .settle_count (settle_count)
    );

    bounce_generator #(.BOUNCE_TICKS(10), .LFSR_SEED(8'h00)) dut_z (
        .clk          (clk),
        .rst          (rst),
        .clean_in     (clean_in),
        .bouncy_out   (z_bouncy_out),
        .settling     (z_settling),
        .settle_count (z_settle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference x^8+x^6+x^5+x^4+1 generators for the seeded and zero-seed instances.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_lfsr   <= 8'hA5;
            m_lfsr_z <= 8'h01;
        end else begin
            m_lfsr   <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_lfsr_z <= {m_lfsr_z[6:0], m_lfsr_z[7] ^ m_lfsr_z[5] ^ m_lfsr_z[4] ^ m_lfsr_z[3]};
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_pat(input logic target, input int idx, input logic [7:0] lf);
`ifdef BOUNCE_GENERATOR_LFSR_EN
        return lf[0];
`else
        return target ^ idx[0];
`endif
    endfunction

    // Called on the negedge just before the posedge that starts (or restarts) the bounce.
    task automatic bounce_check(input logic target, input string tag);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check({tag, "_pat"}, {31'd0, bouncy_out}, {31'd0, exp_pat(target, i, m_lfsr)});
            check({tag, "_settling"}, {31'd0, settling}, 32'd1);
            check({tag, "_z_pat"}, {31'd0, z_bouncy_out}, {31'd0, exp_pat(target, i, m_lfsr_z)});
        end
        @(negedge clk);
        check({tag, "_final"}, {31'd0, bouncy_out}, {31'd0, target});
        check({tag, "_settled"}, {31'd0, settling}, 32'd0);
        check({tag, "_z_settled"}, {31'd0, z_settling}, 32'd0);
    endtask

    initial begin
        rst      = 1'b0;
        clean_in = 1'b0;
        #3;
        check("rst_bouncy", {31'd0, bouncy_out}, 32'd0);
        check("rst_settling", {31'd0, settling}, 32'd0);
        check("rst_count", {24'd0, settle_count}, 32'd0);

        // clean_in already high at the first edge after release
        @(negedge clk);
        rst      = 1'b1;
        clean_in = 1'b1;
        bounce_check(1'b1, "rise");
        check("rise_count", {24'd0, settle_count}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_hi", {30'd0, settling, bouncy_out}, 32'd1);
        end

        clean_in = 1'b0;
        bounce_check(1'b0, "fall");
        check("fall_count", {24'd0, settle_count}, 32'd2);

        // Reversal after four bounce cycles toward 1
        clean_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rev_pre_pat", {31'd0, bouncy_out}, {31'd0, exp_pat(1'b1, i, m_lfsr)});
        end
        clean_in = 1'b0;
        bounce_check(1'b0, "rev");
        check("rev_count", {24'd0, settle_count}, 32'd3);
        check("rev_z_count", {24'd0, z_settle_count}, 32'd3);

        // Async reset with counter at 5, checked before any further edge
        clean_in = 1'b1;
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("pre_rst_settling", {31'd0, settling}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midrst_bouncy", {31'd0, bouncy_out}, 32'd0);
        check("midrst_settling", {31'd0, settling}, 32'd0);
        check("midrst_count", {24'd0, settle_count}, 32'd0);
        @(negedge clk);
        clean_in = 1'b0;
        rst      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {30'd0, settling, bouncy_out}, 32'd0);
        end

        for (int k = 1; k <= 300; k++) begin
            clean_in = ~clean_in;
            for (int j = 0; j < 12; j++) @(negedge clk);
            if (k == 254) check("sat_254", {24'd0, settle_count}, 32'd254);
            if (k == 255) check("sat_255", {24'd0, settle_count}, 32'd255);
        end
        check("sat_300", {24'd0, settle_count}, 32'd255);
        check("sat_z_300", {24'd0, z_settle_count}, 32'd255);
        check("sat_level", {31'd0, bouncy_out}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
